fetch_prefetch_queue: RTL

//  Parametrised IF stage: decoupled prefetcher with a DEPTH-entry instruction queue between IMEM and ID.

---
 rtl/fetch_prefetch_queue_pkg.sv | 30 +++
 rtl/fetch_prefetch_queue_fifo.sv | 65 ++++++
 rtl/fetch_prefetch_queue.sv | 126 ++++++++++++
 3 files changed

// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared types and constants for the decoupled instruction prefetcher.
package fetch_prefetch_queue_pkg;

  typedef enum logic [1:0] {
    ST_ISSUE,
    ST_WAIT,
    ST_DRAIN,
    ST_ERR_HOLD
  } fq_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } fq_entry_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Build a queue entry; faulting fetches carry a NOP so ID never decodes garbage.
  function automatic fq_entry_t make_entry(input logic [31:0] pc,
                                           input logic [31:0] rdata,
                                           input logic        err);
    fq_entry_t e;
    e.pc   = pc;
    e.inst = err ? NOP_INST : rdata;
    e.err  = err;
    return e;
  endfunction

endpackage

// File: rtl/fetch_prefetch_queue_fifo.sv
// DEPTH-entry instruction queue with synchronous flush; flush overrides push/pop.
module fetch_queue_fifo_sbm
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_flush,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  fq_entry_t                    i_wdata,
  output fq_entry_t                    o_rdata,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fq_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  // A pop frees the slot it leaves, so push into a full queue is legal alongside a pop.
  assign w_pop  = i_pop & (r_count != '0) & ~i_flush;
  assign w_push = i_push & ~i_flush & ((r_count != FULL_CNT) | w_pop);

  // Pointer and occupancy bookkeeping; pointers wrap naturally on power-of-2 depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents are only meaningful while counted, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/fetch_prefetch_queue.sv
// IF stage: credit-limited sequential prefetcher feeding an instruction queue.
module fetch_prefetch_queue
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int                ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] INIT_PC = '0,
  parameter int                DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              req_start_o,
  output logic [ADDR_W-1:0] req_addr_o,
  input  logic              req_ready_i,
  input  logic              rsp_valid_i,
  input  logic              rsp_err_i,
  input  logic [31:0]       rsp_rdata_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [31:0]       inst_o,
  output logic [31:0]       pc_o,
  output logic              err_o
);

  localparam int CNT_W = $clog2(DEPTH+1);

  fq_state_e         r_state;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_req_pc;
  logic              r_inflight;

  logic [CNT_W-1:0]  w_count;
  logic              w_full;
  logic              w_empty;
  logic              w_credit;
  logic              w_issue;
  logic              w_outstanding;
  logic              w_push;
  logic              w_pop;
  fq_entry_t         w_wdata;
  fq_entry_t         w_head;
  logic [1:0]        w_unused_pc_lsb;

  // Low PC bits are discarded: fetches are always word aligned.
  assign w_unused_pc_lsb = redirect_pc_i[1:0];

  // Reserving a slot for the in-flight read means every response has somewhere to land.
  assign w_credit      = (int'(w_count) + int'(r_inflight)) < DEPTH;
  assign w_issue       = (r_state == ST_ISSUE) & ~rst & ~redirect_i & req_ready_i & w_credit;
  assign w_outstanding = r_inflight & ~rsp_valid_i;
  assign w_push        = (r_state == ST_WAIT) & rsp_valid_i & ~redirect_i;
  assign w_pop         = valid_o & ready_i;
  assign w_wdata       = make_entry(32'(r_req_pc), rsp_rdata_i, rsp_err_i);

  // Fetch control: redirect wins over everything, else step the issue/wait cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_ISSUE;
      r_fetch_pc <= INIT_PC;
      r_inflight <= 1'b0;
    end else if (redirect_i) begin
      r_fetch_pc <= {redirect_pc_i[ADDR_W-1:2], 2'b00};
      r_inflight <= w_outstanding;
      r_state    <= w_outstanding ? ST_DRAIN : ST_ISSUE;
    end else begin
      case (r_state)
        ST_ISSUE: begin
          if (w_issue) begin
            r_state    <= ST_WAIT;
            r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
            r_inflight <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (rsp_valid_i) begin
            r_inflight <= 1'b0;
            r_state    <= rsp_err_i ? ST_ERR_HOLD : ST_ISSUE;
          end
        end
        ST_DRAIN: begin
          if (rsp_valid_i) begin
            r_inflight <= 1'b0;
            r_state    <= ST_ISSUE;
          end
        end
        ST_ERR_HOLD: r_state <= ST_ERR_HOLD;
        default:     r_state <= ST_ISSUE;
      endcase
    end
  end

  // Remember which PC the outstanding read belongs to.
  always_ff @(posedge clk) begin
    if (w_issue) r_req_pc <= r_fetch_pc;
  end

  fetch_queue_fifo_sbm #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (redirect_i),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wdata),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign req_start_o = w_issue;
  assign req_addr_o  = r_fetch_pc;
  assign valid_o     = ~w_empty;
  // Head fields read as zero while the queue is empty so stale storage never leaks out.
  assign inst_o      = valid_o ? w_head.inst : 32'h0;
  assign pc_o        = valid_o ? w_head.pc   : 32'h0;
  assign err_o       = valid_o & w_head.err;

  a_count_le_depth: assert property (@(posedge clk) disable iff (rst) int'(w_count) <= DEPTH);
  a_no_push_full:   assert property (@(posedge clk) disable iff (rst) !(w_push && w_full));
  a_start_in_issue: assert property (@(posedge clk) disable iff (rst) req_start_o |-> (r_state == ST_ISSUE));
  a_single_flight:  assert property (@(posedge clk) disable iff (rst) !(w_issue && r_inflight));

endmodule
